// File: rtl/pianotiles_pkg.sv
// Shared types and constants for the tile game input path.
package pianotiles_pkg;

  // Tile column index, 0 = leftmost.
  typedef logic [1:0] col_t;

  localparam col_t COL_A = 2'd0;
  localparam col_t COL_B = 2'd1;
  localparam col_t COL_C = 2'd2;
  localparam col_t COL_D = 2'd3;

  localparam int NUM_KEYS            = 4;
  // 5 ms at 50 MHz.
  localparam int DEF_DEBOUNCE_CYCLES = 250000;

  // One queued column event.
  typedef struct packed {
    logic vld;
    col_t col;
  } key_evt_t;

  // KEY[3] is the leftmost button on the board, so bit i maps to column 3-i.
  function automatic col_t key_col(input logic [NUM_KEYS-1:0] onehot);
    col_t c;
    c = COL_A;
    for (int i = 0; i < NUM_KEYS; i++)
      if (onehot[i]) c = col_t'(NUM_KEYS - 1 - i);
    return c;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One push-button: 2-flop synchroniser followed by a stability counter.
// down is 1 while the button is (debounced) pressed.
module key_debouncer import pianotiles_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic resetn,
  input  logic key_n,
  output logic down
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          pressed;

  assign pressed = ~sync[1];

  // Synchroniser; resets to the released (high) level.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) sync <= 2'b11;
    else         sync <= {sync[0], key_n};
  end

  // Count consecutive disagreeing cycles; toggle once the count reaches DEBOUNCE_CYCLES.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt  <= '0;
      down <= 1'b0;
    end else if (pressed == down) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt  <= '0;
      down <= ~down;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/key_event_encoder.sv
// Push-button to column-event encoder: debounce, single-key check, FWFT queue.
// Optional auto-repeat is built when KEY_EVENT_REPEAT_EN is defined.
module key_event_encoder import pianotiles_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int FIFO_DEPTH      = 4,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic                event_valid,
  output col_t                event_col,
  input  logic                event_ready,
  output logic [NUM_KEYS-1:0] keys_down,
  output logic                chord,
  output logic                overflow,
  input  logic                clear_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // ---------------- per-key debounce ----------------
  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock  (clock),
      .resetn (resetn),
      .key_n  (key_n[i]),
      .down   (keys_down[i])
    );
  end

  // ---------------- press edge / chord check ----------------
  logic [NUM_KEYS-1:0] prev_down;
  logic [NUM_KEYS-1:0] press_edge;
  logic                single;
  logic                press_push;
  logic                chord_d;
  key_evt_t            push_req;

  // Previous debounced levels for edge detection.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) prev_down <= '0;
    else         prev_down <= keys_down;
  end

  // A press is valid only if the new key is the sole key held.
  always_comb begin
    press_edge = keys_down & ~prev_down;
    single     = ($countones(keys_down) == 1);
    press_push = (|press_edge) && single;
    chord_d    = (|press_edge) && !single;
  end

  // Chord pulse lines up with the cycle a push would have happened.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) chord <= 1'b0;
    else         chord <= chord_d;
  end

`ifdef KEY_EVENT_REPEAT_EN
  // ---------------- auto-repeat ----------------
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rpt_cnt;
  logic [RW-1:0] rpt_limit;
  logic          rpt_first;
  logic          rpt_arm;
  logic          rpt_fire;

  // Only a key that produced a press event (rpt_arm) may repeat.
  always_comb begin
    rpt_limit = rpt_first ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1);
    rpt_fire  = rpt_arm && single && (keys_down == prev_down) && (rpt_cnt == rpt_limit);
  end

  // Repeat timer; restarts on any change of the debounced levels.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
      rpt_arm   <= 1'b0;
    end else if (keys_down != prev_down) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
      rpt_arm   <= press_push;
    end else if (!single) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
      rpt_arm   <= 1'b0;
    end else if (rpt_fire) begin
      rpt_cnt   <= '0;
      rpt_first <= 1'b0;
    end else begin
      rpt_cnt <= rpt_cnt + 1'b1;
    end
  end

  assign push_req.vld = press_push || rpt_fire;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign push_req.vld      = press_push;
`endif

  assign push_req.col = key_col(keys_down);

  // ---------------- FWFT event queue ----------------
  col_t [FIFO_DEPTH-1:0] mem;
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  empty;
  logic                  full;
  logic                  pop;
  logic                  wr_en;

  // Pointers carry an extra wrap bit to tell full from empty.
  always_comb begin
    empty       = (wr_ptr == rd_ptr);
    full        = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    event_valid = !empty;
    pop         = event_valid && event_ready;
    wr_en       = push_req.vld && (!full || pop);
    event_col   = event_valid ? mem[rd_ptr[AW-1:0]] : COL_A;
  end

  // Storage; when full with a pop, the write lands in the slot being vacated.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)    mem <= '0;
    else if (wr_en) mem[wr_ptr[AW-1:0]] <= push_req.col;
  end

  // Queue pointers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky drop flag; a new drop wins over a clear in the same cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)                             overflow <= 1'b0;
    else if (push_req.vld && full && !pop)   overflow <= 1'b1;
    else if (clear_overflow)                 overflow <= 1'b0;
  end

endmodule

// File: tb/tb_key_event_encoder.sv
// Directed self-checking bench for key_event_encoder (DEBOUNCE_CYCLES=8, FIFO_DEPTH=4).
module tb_key_event_encoder;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [3:0] key_n = 4'hF;
  logic       event_valid;
  logic [1:0] event_col;
  logic       event_ready = 1'b0;
  logic [3:0] keys_down;
  logic       chord;
  logic       overflow;
  logic       clear_overflow = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  key_event_encoder #(.DEBOUNCE_CYCLES(8), .FIFO_DEPTH(4)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .key_n          (key_n),
    .event_valid    (event_valid),
    .event_col      (event_col),
    .event_ready    (event_ready),
    .keys_down      (keys_down),
    .chord          (chord),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Press key k long enough for one event, then release and let it settle.
  task automatic tap(input int k);
    key_n[k] = 1'b0;
    step(13);
    key_n[k] = 1'b1;
    step(13);
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    step(3);
    checks++;
    if ({event_valid, event_col, keys_down, chord, overflow} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 000000000", {event_valid, event_col, keys_down, chord, overflow});
    end
    resetn = 1'b1;
    step(4);
    checks++;
    if (event_valid !== 1'b0) begin
      errors++; $display("FAIL reset_idle_valid: got %b expected 0", event_valid);
    end
  endtask

  task automatic test_clean_press;
    logic saw;
    event_ready = 1'b1;
    key_n = 4'b1101;
    step(10);
    checks++;
    if (event_valid !== 1'b0) begin
      errors++; $display("FAIL press_early: valid got %b expected 0 at edge 10", event_valid);
    end
    step(1);
    checks++;
    if (event_valid !== 1'b1) begin
      errors++; $display("FAIL press_latency: valid got %b expected 1 at edge 11", event_valid);
    end
    checks++;
    if (event_col !== 2'd2) begin
      errors++; $display("FAIL press_col: got %0d expected 2", event_col);
    end
    checks++;
    if (keys_down !== 4'b0010) begin
      errors++; $display("FAIL press_keys_down: got %b expected 0010", keys_down);
    end
    step(1);
    checks++;
    if (event_valid !== 1'b0) begin
      errors++; $display("FAIL press_one_event: valid got %b expected 0", event_valid);
    end
    step(8);
    key_n = 4'hF;
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (event_valid) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++; $display("FAIL release_event: saw valid %b expected 0", saw);
    end
    checks++;
    if (keys_down !== 4'b0000) begin
      errors++; $display("FAIL release_keys_down: got %b expected 0000", keys_down);
    end
  endtask

  task automatic test_bounce;
    logic saw_down, saw_valid, saw_chord;
    saw_down = 1'b0; saw_valid = 1'b0; saw_chord = 1'b0;
    event_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      key_n[3] = (i % 2 == 0) ? 1'b0 : 1'b1;
      for (int j = 0; j < 3; j++) begin
        step(1);
        if (keys_down != 4'b0) saw_down = 1'b1;
        if (event_valid) saw_valid = 1'b1;
        if (chord) saw_chord = 1'b1;
      end
    end
    key_n = 4'hF;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (keys_down != 4'b0) saw_down = 1'b1;
      if (event_valid) saw_valid = 1'b1;
      if (chord) saw_chord = 1'b1;
    end
    checks++;
    if (saw_down !== 1'b0) begin
      errors++; $display("FAIL bounce_keys_down: saw %b expected 0", saw_down);
    end
    checks++;
    if (saw_valid !== 1'b0) begin
      errors++; $display("FAIL bounce_event: saw %b expected 0", saw_valid);
    end
    checks++;
    if (saw_chord !== 1'b0) begin
      errors++; $display("FAIL bounce_chord: saw %b expected 0", saw_chord);
    end
  endtask

  task automatic test_chord;
    int  nch;
    logic sv;
    event_ready = 1'b1;
    // keys 0 and 2 fall together
    key_n = 4'b1010;
    nch = 0; sv = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (chord) nch++;
      if (event_valid) sv = 1'b1;
    end
    checks++;
    if (nch !== 1) begin
      errors++; $display("FAIL chord_same_cycle_pulses: got %0d expected 1", nch);
    end
    checks++;
    if (sv !== 1'b0) begin
      errors++; $display("FAIL chord_same_cycle_event: saw %b expected 0", sv);
    end
    checks++;
    if (keys_down !== 4'b0101) begin
      errors++; $display("FAIL chord_keys_down: got %b expected 0101", keys_down);
    end
    // release key 2, keep key 0 held
    key_n = 4'b1110;
    step(12);
    checks++;
    if (keys_down !== 4'b0001) begin
      errors++; $display("FAIL chord_held_keys_down: got %b expected 0001", keys_down);
    end
    // press key 1 while key 0 is held
    key_n = 4'b1100;
    nch = 0; sv = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (chord) nch++;
      if (event_valid) sv = 1'b1;
    end
    checks++;
    if (nch !== 1) begin
      errors++; $display("FAIL chord_held_pulses: got %0d expected 1", nch);
    end
    checks++;
    if (sv !== 1'b0) begin
      errors++; $display("FAIL chord_held_event: saw %b expected 0", sv);
    end
    key_n = 4'hF;
    step(12);
  endtask

  task automatic test_overflow;
    logic [1:0] exp_cols [4];
    exp_cols = '{2'd0, 2'd1, 2'd2, 2'd3};
    event_ready = 1'b0;
    tap(3); tap(2); tap(1); tap(0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_not_yet: got %b expected 0", overflow);
    end
    tap(3);
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set: got %b expected 1", overflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (event_valid !== 1'b1 || event_col !== exp_cols[i]) begin
        errors++;
        $display("FAIL ovf_drain_%0d: valid %b col %0d expected valid 1 col %0d", i, event_valid, event_col, exp_cols[i]);
      end
      event_ready = 1'b1;
      step(1);
      event_ready = 1'b0;
    end
    checks++;
    if (event_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_empty: valid got %b expected 0", event_valid);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow);
    end
    clear_overflow = 1'b1;
    step(1);
    clear_overflow = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b expected 0", overflow);
    end
  endtask

  task automatic test_full_pop;
    logic [1:0] exp_cols [4];
    exp_cols = '{2'd1, 2'd2, 2'd3, 2'd2};
    event_ready = 1'b0;
    tap(3); tap(2); tap(1); tap(0);
    key_n[1] = 1'b0;
    step(10);
    checks++;
    if (event_valid !== 1'b1 || event_col !== 2'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pre: valid %b col %0d ovf %b expected 1 0 0", event_valid, event_col, overflow);
    end
    // pop exactly on the edge the column-2 press is pushed
    event_ready = 1'b1;
    step(1);
    event_ready = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL full_pop_no_drop: ovf got %b expected 0", overflow);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (event_valid !== 1'b1 || event_col !== exp_cols[i]) begin
        errors++;
        $display("FAIL full_pop_drain_%0d: valid %b col %0d expected valid 1 col %0d", i, event_valid, event_col, exp_cols[i]);
      end
      event_ready = 1'b1;
      step(1);
      event_ready = 1'b0;
    end
    checks++;
    if (event_valid !== 1'b0) begin
      errors++; $display("FAIL full_pop_empty: valid got %b expected 0", event_valid);
    end
    key_n = 4'hF;
    step(13);
  endtask

  task automatic test_reset_mid;
    event_ready = 1'b0;
    tap(3); tap(2);
    key_n[1] = 1'b0;
    step(12);
    checks++;
    if (event_valid !== 1'b1 || keys_down !== 4'b0010) begin
      errors++; $display("FAIL rmid_pre: valid %b keys %b expected 1 0010", event_valid, keys_down);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({event_valid, event_col, keys_down, chord, overflow} !== 9'b0) begin
      errors++;
      $display("FAIL rmid_async: got %b expected 000000000", {event_valid, event_col, keys_down, chord, overflow});
    end
    step(2);
    resetn = 1'b1;
    event_ready = 1'b1;
    step(10);
    checks++;
    if (event_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_early: valid got %b expected 0 at edge 10", event_valid);
    end
    step(1);
    checks++;
    if (event_valid !== 1'b1 || event_col !== 2'd2) begin
      errors++; $display("FAIL rmid_event: valid %b col %0d expected 1 2", event_valid, event_col);
    end
    step(1);
    checks++;
    if (event_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_single: valid got %b expected 0", event_valid);
    end
    key_n = 4'hF;
    event_ready = 1'b0;
    step(13);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_chord();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
